// File: rtl/mppt_pkg.sv
// Shared encodings for the perturb-and-observe MPPT tracker.
// FSM state codes and perturbation direction constants.
package mppt_pkg;

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_DECIDE = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    ST_WAIT   = S_WAIT,
    ST_DECIDE = S_DECIDE,
    ST_SETTLE = S_SETTLE
  } state_t;

endpackage

// File: rtl/mppt_duty_clamp.sv
// Steps a duty word by +/-step and saturates it into [duty_min, duty_max].
// Ports: duty, step, dir, duty_min, duty_max in; duty_next, hit_lo, hit_hi out.
module mppt_duty_clamp #(
  parameter int D_BITS    = 8,
  parameter int STEP_BITS = 4
) (
  input  logic [D_BITS-1:0]    duty,
  input  logic [STEP_BITS-1:0] step,
  input  logic                 dir,
  input  logic [D_BITS-1:0]    duty_min,
  input  logic [D_BITS-1:0]    duty_max,
  output logic [D_BITS-1:0]    duty_next,
  output logic                 hit_lo,
  output logic                 hit_hi
);
  import mppt_pkg::*;

  localparam int W = D_BITS + 1;

  logic [W-1:0] duty_w;
  logic [W-1:0] step_w;
  logic [W-1:0] lo_w;
  logic [W-1:0] hi_w;
  logic [W-1:0] raw;
  logic [W-1:0] t;
  logic [W-1:0] res;
  logic         under;

  always_comb begin
    duty_w = {1'b0, duty};
    step_w = W'(step);
    lo_w   = {1'b0, duty_min};
    hi_w   = {1'b0, duty_max};
    // a borrow means the true result is negative
    under  = (dir == DIR_DN) && (step_w > duty_w);
    if (dir == DIR_UP)
      raw = duty_w + step_w;
    else if (under)
      raw = '0;
    else
      raw = duty_w - step_w;
    hit_lo = under || (raw < lo_w);
    t      = hit_lo ? lo_w : raw;
    // max bound applied last so an inverted window yields duty_max
    hit_hi = t > hi_w;
    res    = hit_hi ? hi_w : t;
  end

  assign duty_next = res[D_BITS-1:0];

endmodule

// File: rtl/mppt_po_ctrl.sv
// Perturb-and-observe MPPT controller with settle interval and manual mode.
// Ports: clk, reset, enable, mode, manual_duty, step, settle_cycles, duty_min/max, sample_valid, v, i; duty, duty_valid, dir, sample_ready.
module mppt_po_ctrl #(
  parameter int N_BITS    = 12,
  parameter int D_BITS    = 8,
  parameter int STEP_BITS = 4,
  parameter int SETTLE_W  = 8,
  parameter int DUTY_INIT = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [D_BITS-1:0]    manual_duty,
  input  logic [STEP_BITS-1:0] step,
  input  logic [SETTLE_W-1:0]  settle_cycles,
  input  logic [D_BITS-1:0]    duty_min,
  input  logic [D_BITS-1:0]    duty_max,
  input  logic                 sample_valid,
  input  logic [N_BITS-1:0]    v,
  input  logic [N_BITS-1:0]    i,
  output logic [D_BITS-1:0]    duty,
  output logic                 duty_valid,
  output logic                 dir,
  output logic                 sample_ready
);
  import mppt_pkg::*;

  localparam int PW = 2 * N_BITS;

  state_t              state;
  logic [PW-1:0]       p_q;
  logic [PW-1:0]       p_old;
  logic                first;
  logic                cmp_done;
  logic                p_gt;
  logic                p_lt;
  logic [SETTLE_W-1:0] cnt;

  logic                 new_dir;
  logic [D_BITS-1:0]    c_duty;
  logic [STEP_BITS-1:0] c_step;
  logic                 c_dir;
  logic [D_BITS-1:0]    c_next;
  logic                 c_lo;
  logic                 c_hi;

  assign new_dir = p_lt ? ~dir : dir;

  // one clamp serves both paths; manual mode clamps the request as-is
  assign c_duty = mode ? manual_duty : duty;
  assign c_step = mode ? '0 : step;
  assign c_dir  = mode ? DIR_UP : new_dir;

  mppt_duty_clamp #(
    .D_BITS    (D_BITS),
    .STEP_BITS (STEP_BITS)
  ) u_clamp (
    .duty      (c_duty),
    .step      (c_step),
    .dir       (c_dir),
    .duty_min  (duty_min),
    .duty_max  (duty_max),
    .duty_next (c_next),
    .hit_lo    (c_lo),
    .hit_hi    (c_hi)
  );

  assign sample_ready = (state == ST_WAIT) && enable && !mode;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_WAIT;
      duty       <= D_BITS'(DUTY_INIT);
      dir        <= DIR_UP;
      duty_valid <= 1'b0;
      p_q        <= '0;
      p_old      <= '0;
      first      <= 1'b1;
      cmp_done   <= 1'b0;
      p_gt       <= 1'b0;
      p_lt       <= 1'b0;
      cnt        <= '0;
    end else begin
      duty_valid <= 1'b0;
      if (!enable) begin
        state    <= ST_WAIT;
        first    <= 1'b1;
        cmp_done <= 1'b0;
      end else if (mode) begin
        duty     <= c_next;
        state    <= ST_WAIT;
        first    <= 1'b1;
        cmp_done <= 1'b0;
      end else begin
        unique case (state)
          ST_WAIT: begin
            if (sample_valid) begin
              p_q      <= PW'(v) * PW'(i);
              cmp_done <= 1'b0;
              state    <= ST_DECIDE;
            end
          end
          ST_DECIDE: begin
            // first cycle registers the wide compare, second applies it
            if (!cmp_done) begin
              p_gt     <= p_q > p_old;
              p_lt     <= p_q < p_old;
              cmp_done <= 1'b1;
            end else begin
              duty_valid <= 1'b1;
              p_old      <= p_q;
              cnt        <= settle_cycles;
              cmp_done   <= 1'b0;
              state      <= ST_SETTLE;
              if (first) begin
                first <= 1'b0;
              end else if (p_gt || p_lt) begin
                duty <= c_next;
                if (c_hi)
                  dir <= DIR_DN;
                else if (c_lo)
                  dir <= DIR_UP;
                else
                  dir <= new_dir;
              end
            end
          end
          ST_SETTLE: begin
            if (cnt == '0)
              state <= ST_WAIT;
            else
              cnt <= cnt - SETTLE_W'(1);
          end
          default: state <= ST_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_po_ctrl.sv
// Directed bench for mppt_po_ctrl with hand-computed expectations.
// Drives inputs #1 after the rising edge and checks there too.
module tb_mppt_po_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [7:0]  manual_duty;
  logic [3:0]  step;
  logic [7:0]  settle_cycles;
  logic [7:0]  duty_min;
  logic [7:0]  duty_max;
  logic        sample_valid;
  logic [11:0] v;
  logic [11:0] i;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        dir;
  logic        sample_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mppt_po_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .manual_duty   (manual_duty),
    .step          (step),
    .settle_cycles (settle_cycles),
    .duty_min      (duty_min),
    .duty_max      (duty_max),
    .sample_valid  (sample_valid),
    .v             (v),
    .i             (i),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .dir           (dir),
    .sample_ready  (sample_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input int vv, input int ii,
                      input int exp_d, input int exp_dir);
    int n;
    n = 0;
    while (!sample_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(sample_ready), 1);
    if (!sample_ready) return;
    sample_valid = 1'b1;
    v = 12'(vv);
    i = 12'(ii);
    tick();
    sample_valid = 1'b0;
    tick();
    check_eq({tag, "_dv_early"}, 32'(duty_valid), 0);
    tick();
    check_eq({tag, "_dv"}, 32'(duty_valid), 1);
    check_eq({tag, "_duty"}, 32'(duty), 32'(exp_d));
    check_eq({tag, "_dir"}, 32'(dir), 32'(exp_dir));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    mode = 1'b0;
    manual_duty = 8'd0;
    step = 4'd2;
    settle_cycles = 8'd3;
    duty_min = 8'd0;
    duty_max = 8'd255;
    sample_valid = 1'b0;
    v = '0;
    i = '0;
    tick();
    tick();
    reset = 1'b1;
    check_eq("rst_duty", 32'(duty), 128);
    check_eq("rst_dir", 32'(dir), 1);
    check_eq("rst_dv", 32'(duty_valid), 0);
    check_eq("rst_rdy", 32'(sample_ready), 1);

    // baseline, then settle window of settle_cycles+1 clocks
    send("s1_first", 100, 10, 128, 1);
    tick();
    tick();
    tick();
    check_eq("s1_rdy_low", 32'(sample_ready), 0);
    tick();
    check_eq("s1_rdy_back", 32'(sample_ready), 1);

    send("s2_up", 110, 10, 130, 1);
    send("s3_down", 90, 10, 128, 0);
    send("s4_up", 100, 10, 126, 0);
    send("s5_equal", 100, 10, 126, 0);
    send("s6_flip", 90, 10, 128, 1);
    send("s7_up", 95, 10, 130, 1);

    duty_max = 8'd131;
    step = 4'd4;
    send("s8_clamp_hi", 100, 10, 131, 0);

    duty_max = 8'd200;
    mode = 1'b1;
    manual_duty = 8'd250;
    tick();
    check_eq("man_duty", 32'(duty), 200);
    check_eq("man_dv", 32'(duty_valid), 0);
    check_eq("man_rdy", 32'(sample_ready), 0);
    duty_min = 8'd100;
    duty_max = 8'd50;
    manual_duty = 8'd70;
    tick();
    check_eq("man_inverted", 32'(duty), 50);
    duty_min = 8'd20;
    duty_max = 8'd200;
    manual_duty = 8'd22;
    tick();
    check_eq("man_22", 32'(duty), 22);
    mode = 1'b0;

    send("s9_rebase", 50, 10, 22, 0);
    send("s10_clamp_lo", 60, 10, 20, 1);
    step = 4'd0;
    send("s11_step0", 50, 10, 20, 0);

    // sample offered mid-settle must be ignored
    sample_valid = 1'b1;
    v = 12'd4000;
    i = 12'd4000;
    tick();
    sample_valid = 1'b0;
    check_eq("ign_rdy", 32'(sample_ready), 0);
    check_eq("ign_dv", 32'(duty_valid), 0);
    check_eq("ign_duty", 32'(duty), 20);

    reset = 1'b0;
    tick();
    check_eq("rst2_duty", 32'(duty), 128);
    check_eq("rst2_dir", 32'(dir), 1);
    check_eq("rst2_rdy", 32'(sample_ready), 1);
    reset = 1'b1;
    step = 4'd2;
    send("s12_after_rst", 30, 10, 128, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mppt_po_ctrl.md
# mppt_po_ctrl

Parametrised perturb-and-observe MPPT controller that replaces the fixed 12-bit tracker in the solar front end. It accepts qualified V/I samples from the ADC sequencer and computes full-width power. It then steps the PWM duty up or down by a programmable step, clamped to a programmable window. A settle interval after every duty change keeps converter transients out of the power comparison, and a manual mode lets firmware drive duty directly.

## Interface
Parameters:
- N_BITS, 12, width of V and I samples (unsigned)
- D_BITS, 8, width of duty word
- STEP_BITS, 4, width of perturbation step
- SETTLE_W, 8, width of settle counter
- DUTY_INIT, 128, duty after reset (must lie in 0..2^D_BITS-1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- enable  in  1  1 = tracking/manual active; 0 = freeze duty
- mode  in  1  0 = P&O tracking, 1 = manual
- manual_duty  in  D_BITS  duty requested in manual mode
- step  in  STEP_BITS  perturbation magnitude
- settle_cycles  in  SETTLE_W  clocks to wait after each duty change
- duty_min  in  D_BITS  lower duty bound
- duty_max  in  D_BITS  upper duty bound
- sample_valid  in  1  v/i qualified this cycle
- v  in  N_BITS  voltage sample
- i  in  N_BITS  current sample
- duty  out  D_BITS  registered PWM duty
- duty_valid  out  1  one-cycle pulse when duty is (re)written by the tracker
- dir  out  1  current perturbation direction, 1 = increasing
- sample_ready  out  1  high in WAIT, meaning a sample will be accepted

## Operation
- Power p = v*i, full 2*N_BITS unsigned. No truncation; p_old has the same width.
- FSM states: WAIT, DECIDE, SETTLE.
  - WAIT: if sample_valid, register p and go to DECIDE. sample_valid outside WAIT is ignored.
  - DECIDE: if the first flag is set, store p_old=p, clear first, leave duty unchanged, pulse duty_valid and go to SETTLE. Otherwise apply the decision rule, then go to SETTLE.
  - SETTLE: load counter with settle_cycles on entry, decrement each clock, return to WAIT when it reaches 0. settle_cycles=0 means SETTLE lasts exactly one cycle.
- Decision rule:
  - p > p_old: keep dir.
  - p < p_old: invert dir.
  - p == p_old: keep dir and leave duty unchanged (hold).
  - Otherwise duty_next = duty ± step in the new dir.
  - Then p_old = p.
- Saturation:
  - duty_next is computed with D_BITS+1 bits and clamped to [duty_min, duty_max].
  - If the clamp engages, dir is forced to point inward (1 at duty_min, 0 at duty_max).
  - If duty_min > duty_max, the output equals duty_max (apply the max-with-min first, then the min-with-max).
- step=0: duty unchanged, dir rule still applied, duty_valid still pulses.
- Manual mode (mode=1, enable=1):
  - duty <= clamp(manual_duty) every cycle.
  - FSM forced to WAIT with first=1; duty_valid is low.
  - Returning to mode=0 re-baselines on the next sample.
- enable=0: duty and dir hold, FSM forced to WAIT, first=1, duty_valid=0, sample_ready=0.

## Timing
- Reset values (reset=0 at a clk edge): duty=DUTY_INIT, dir=1, duty_valid=0, sample_ready=1 (state WAIT), p_old=0, first=1, counter=0.
- Reset mid-operation aborts any state on that edge.
- Sample accepted at edge k (state WAIT, sample_valid=1): DECIDE during cycle k+1, and duty/dir/duty_valid update at edge k+2.
- Sample-to-duty latency is 2 clocks. The next sample is accepted no earlier than settle_cycles+1 clocks after the duty update.
- Manual duty latency is 1 clock.
- enable or mode changes take effect at the next edge and preempt DECIDE/SETTLE. An interrupted DECIDE does not update duty.

## Structure
- Package mppt_pkg holds:
  - state encoding localparams: S_WAIT=2'd0, S_DECIDE=2'd1, S_SETTLE=2'd2
  - DIR_UP=1'b1 and DIR_DN=1'b0
- Sub-module mppt_duty_clamp (combinational) takes duty, step, dir, duty_min and duty_max. It outputs the saturated duty_next and a hit_lo/hit_hi flag. It is reused by the manual path with step=0.

## Test plan
- Reset, then the first sample v=100,i=10 with settle_cycles=3: duty stays 128 and duty_valid pulses 2 clocks after acceptance. sample_ready returns after 4 clocks.
- Increasing power (second sample p=1100 > 1000, step=2): duty 130, dir=1. A third sample with p=900 gives duty 128, dir=0.
- Equal power p=1000 twice: duty unchanged, dir unchanged, duty_valid pulses.
- Clamp: duty_max=131, duty=130, step=4, rising power: duty=131 and dir forced 0. Mirror this at duty_min=20.
- Manual: mode=1, manual_duty=250, duty_max=200: duty=200 after 1 clock, with no duty_valid pulse. On return to mode=0, the next sample re-baselines and duty is unchanged.
- Reset asserted during SETTLE, and sample_valid pulsed during SETTLE: the ignored sample causes no change. After reset, duty=128, dir=1, state WAIT.
